// File: rtl/switch_allocator_pkg.sv
// rtl/switch_allocator_pkg.sv - shared port indices, select encoding and FSM states
package switch_allocator_pkg;

  localparam int N_BIT_SEL = 3;
  localparam int N_PORT    = 5;

  localparam logic [N_BIT_SEL-1:0] PORT_L   = 3'd0;
  localparam logic [N_BIT_SEL-1:0] PORT_N   = 3'd1;
  localparam logic [N_BIT_SEL-1:0] PORT_E   = 3'd2;
  localparam logic [N_BIT_SEL-1:0] PORT_S   = 3'd3;
  localparam logic [N_BIT_SEL-1:0] PORT_W   = 3'd4;
  localparam logic [N_BIT_SEL-1:0] SEL_NONE = 3'd7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  // Round-robin successor of a port index, wrapping W back to L.
  function automatic logic [N_BIT_SEL-1:0] next_port(input logic [N_BIT_SEL-1:0] p);
    return (p == PORT_W) ? PORT_L : p + 3'd1;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// rtl/switch_allocator_if.sv - per-port request/select/grant bundle of the allocator
interface switch_allocator_if;
  import switch_allocator_pkg::*;

  logic [N_PORT-1:0]                req;
  logic [N_PORT-1:0][N_BIT_SEL-1:0] dest;
  logic [N_PORT-1:0]                tail;
  logic [N_PORT-1:0]                out_ready;
  logic [N_PORT-1:0][N_BIT_SEL-1:0] select;
  logic [N_PORT-1:0]                grant;
  logic [N_PORT-1:0]                out_valid;

  modport master (
    output req, dest, tail, out_ready,
    input  select, grant, out_valid
  );

  modport slave (
    input  req, dest, tail, out_ready,
    output select, grant, out_valid
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter_5.sv
// rtl/switch_allocator_rr_arbiter_5.sv - combinational 5-way round-robin pick starting at ptr
module rr_arbiter_5
  import switch_allocator_pkg::*;
(
  input  logic [N_PORT-1:0]    req,
  input  logic [N_BIT_SEL-1:0] ptr,
  output logic [N_PORT-1:0]    gnt_oh,
  output logic [N_BIT_SEL-1:0] gnt_idx
);

  logic [N_BIT_SEL:0] cand;
  logic               found;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = SEL_NONE;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < N_PORT; k++) begin
      // ptr is at most 4, so one subtraction is enough to wrap mod 5
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(N_PORT)) begin
        cand = cand - 4'(N_PORT);
      end
      if (!found && req[cand[N_BIT_SEL-1:0]]) begin
        found                         = 1'b1;
        gnt_idx                       = cand[N_BIT_SEL-1:0];
        gnt_oh[cand[N_BIT_SEL-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output wormhole allocator: round-robin lock until tail flit
module switch_allocator
  import switch_allocator_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  switch_allocator_if.slave bus
);

  logic [N_PORT-1:0][N_PORT-1:0]    req_vec;
  logic [N_PORT-1:0][N_PORT-1:0]    win_oh;
  logic [N_PORT-1:0][N_BIT_SEL-1:0] win_idx;

  alloc_state_e                     state_q [N_PORT];
  alloc_state_e                     state_d [N_PORT];
  logic [N_PORT-1:0][N_BIT_SEL-1:0] owner_q, owner_d;
  logic [N_PORT-1:0][N_BIT_SEL-1:0] ptr_q, ptr_d;
  logic [N_PORT-1:0][N_BIT_SEL-1:0] sel_q, sel_d;
  logic [N_PORT-1:0]                xfer;
  logic [N_PORT-1:0]                grant;
  logic [N_PORT-1:0]                out_valid;

  // req_vec[o][i]: input i wants output o; destinations above W never match
  always_comb begin
    req_vec = '0;
    for (int o = 0; o < N_PORT; o++) begin
      for (int i = 0; i < N_PORT; i++) begin
        req_vec[o][i] = bus.req[i] && (bus.dest[i] == 3'(o));
      end
    end
  end

  for (genvar g = 0; g < N_PORT; g++) begin : g_arb
    rr_arbiter_5 u_arb (
      .req     (req_vec[g]),
      .ptr     (ptr_q[g]),
      .gnt_oh  (win_oh[g]),
      .gnt_idx (win_idx[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    xfer      = '0;
    grant     = '0;
    out_valid = '0;
    for (int o = 0; o < N_PORT; o++) begin
      case (state_q[o])
        ST_IDLE: begin
          if (|win_oh[o]) begin
            state_d[o] = ST_LOCKED;
            owner_d[o] = win_idx[o];
            ptr_d[o]   = next_port(win_idx[o]);
            sel_d[o]   = win_idx[o];
          end
        end
        ST_LOCKED: begin
          // a stalled or silent owner keeps the lock; nothing else can win meanwhile
          xfer[o] = bus.req[owner_q[o]] && bus.out_ready[o];
          if (xfer[o]) begin
            out_valid[o]        = 1'b1;
            grant[owner_q[o]]   = 1'b1;
            if (bus.tail[owner_q[o]]) begin
              state_d[o] = ST_IDLE;
              sel_d[o]   = SEL_NONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < N_PORT; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= PORT_L;
        ptr_q[o]   <= PORT_L;
        sel_q[o]   <= SEL_NONE;
      end
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.select    = sel_q;
  assign bus.grant     = grant;
  assign bus.out_valid = out_valid;

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed and randomized bench against a packet-level allocator model
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  switch_allocator_if bus ();

  switch_allocator u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which input owns each output (if any) and where its next search starts.
  bit       m_locked [5];
  int       m_owner  [5];
  int       m_ptr    [5];
  bit [4:0] m_grant;
  bit [4:0] m_valid;

  int pkt_len  [5];
  int pkt_dest [5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int o = 0; o < 5; o++) begin
      m_locked[o] = 1'b0;
      m_owner[o]  = 0;
      m_ptr[o]    = 0;
    end
  endfunction

  function automatic void model_comb();
    m_grant = '0;
    m_valid = '0;
    for (int o = 0; o < 5; o++) begin
      if (m_locked[o] && bus.req[m_owner[o]] && bus.out_ready[o]) begin
        m_grant[m_owner[o]] = 1'b1;
        m_valid[o]          = 1'b1;
      end
    end
  endfunction

  function automatic void model_edge();
    for (int o = 0; o < 5; o++) begin
      if (m_locked[o]) begin
        if (m_valid[o] && bus.tail[m_owner[o]]) m_locked[o] = 1'b0;
      end else begin
        bit found = 1'b0;
        for (int k = 0; k < 5; k++) begin
          int i = (m_ptr[o] + k) % 5;
          if (!found && bus.req[i] && int'(bus.dest[i]) == o) begin
            found       = 1'b1;
            m_locked[o] = 1'b1;
            m_owner[o]  = i;
            m_ptr[o]    = (i + 1) % 5;
          end
        end
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [4:0][2:0] exp_sel;
    model_comb();
    for (int o = 0; o < 5; o++) exp_sel[o] = m_locked[o] ? 3'(m_owner[o]) : 3'd7;
    check_eq({tag, "_select"},    32'(bus.select),    32'(exp_sel));
    check_eq({tag, "_grant"},     32'(bus.grant),     32'(m_grant));
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_valid));
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step(input string tag);
    #1 compare_all(tag);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req       = '0;
    bus.dest      = '0;
    bus.tail      = '0;
    bus.out_ready = '0;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 5; i++) begin
      bus.req[i]       = 1'($urandom_range(0, 1));
      bus.dest[i]      = 3'($urandom_range(0, 7));
      bus.tail[i]      = 1'($urandom_range(0, 1));
      bus.out_ready[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int sel_seq [8] = '{7, 0, 7, 1, 7, 3, 7, 0};
    int rdy_seq [4] = '{1, 0, 0, 1};

    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);

    // Reset held with random inputs: nothing may lock or grant
    for (int c = 0; c < 4; c++) begin
      randomize_inputs();
      step("reset_hold");
    end
    clear_inputs();
    rst_n = 1'b1;
    step("idle");

    // Single 3-flit packet W -> E
    bus.req[4] = 1'b1; bus.dest[4] = 3'd2; bus.out_ready[2] = 1'b1;
    #1 check_eq("t2_sel_before", 32'(bus.select[2]), 32'd7);
    step("t2_req");
    for (int f = 1; f <= 3; f++) begin
      bus.tail[4] = (f == 3);
      #1;
      check_eq("t2_sel_e",   32'(bus.select[2]),    32'd4);
      check_eq("t2_grant_w", 32'(bus.grant[4]),     32'd1);
      check_eq("t2_valid_e", 32'(bus.out_valid[2]), 32'd1);
      step("t2");
    end
    clear_inputs();
    #1 check_eq("t2_sel_after", 32'(bus.select[2]), 32'd7);
    step("t2_done");

    // Contention on N from L, N, S with single-flit packets
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || i == 1 || i == 3) begin
        bus.req[i] = 1'b1; bus.dest[i] = 3'd1; bus.tail[i] = 1'b1;
      end
    end
    bus.out_ready[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check_eq("t3_sel_n", 32'(bus.select[1]), 32'(sel_seq[c]));
      check_eq("t3_grant", 32'(bus.grant), (c % 2 == 1) ? (32'd1 << sel_seq[c]) : 32'd0);
      if (c == 6) check_eq("t3_ptr_n", 32'(u_dut.ptr_q[1]), 32'd4);
      step("t3");
    end

    // Back-pressure on S owned by E, with N competing
    do_reset();
    bus.req[2] = 1'b1; bus.dest[2] = 3'd3; bus.out_ready[3] = 1'b1;
    step("t4_lock");
    bus.req[1] = 1'b1; bus.dest[1] = 3'd3;
    for (int c = 0; c < 4; c++) begin
      bus.out_ready[3] = 1'(rdy_seq[c]);
      #1;
      check_eq("t4_grant_e", 32'(bus.grant[2]),     32'(rdy_seq[c]));
      check_eq("t4_valid_s", 32'(bus.out_valid[3]), 32'(rdy_seq[c]));
      check_eq("t4_sel_s",   32'(bus.select[3]),    32'd2);
      check_eq("t4_grant_n", 32'(bus.grant[1]),     32'd0);
      step("t4");
    end
    bus.tail[2] = 1'b1;
    step("t4_tail");
    bus.req[2] = 1'b0; bus.tail[2] = 1'b0;
    step("t4_bubble");
    #1 check_eq("t4_sel_next", 32'(bus.select[3]), 32'd1);
    step("t4_next");

    // Parallel non-conflicting traffic L->E, E->W, N->S
    do_reset();
    bus.req[0] = 1'b1; bus.dest[0] = 3'd2;
    bus.req[2] = 1'b1; bus.dest[2] = 3'd4;
    bus.req[1] = 1'b1; bus.dest[1] = 3'd3;
    bus.out_ready = 5'b11111;
    step("t5_req");
    bus.tail[0] = 1'b1; bus.tail[1] = 1'b1; bus.tail[2] = 1'b1;
    #1;
    check_eq("t5_grant", 32'(bus.grant),     32'b00111);
    check_eq("t5_valid", 32'(bus.out_valid), 32'b11100);
    step("t5_xfer");
    clear_inputs();
    step("t5_done");

    // Asynchronous reset in the middle of a packet
    do_reset();
    bus.req[4] = 1'b1; bus.dest[4] = 3'd2; bus.out_ready[2] = 1'b1;
    step("t6_lock");
    step("t6_flit");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("t6_async_sel",   32'(bus.select), 32'h7fff);
    check_eq("t6_async_grant", 32'(bus.grant),  32'd0);
    @(negedge clk);
    step("t6_held");
    clear_inputs();
    rst_n = 1'b1;

    // Out-of-range destination is never granted
    bus.req[0] = 1'b1; bus.dest[0] = 3'd5; bus.out_ready = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("t6_bad_dest_sel",   32'(bus.select), 32'h7fff);
      check_eq("t6_bad_dest_grant", 32'(bus.grant),  32'd0);
      step("t6_bad_dest");
    end

    // Randomized packet traffic with occasional resets
    do_reset();
    for (int i = 0; i < 5; i++) pkt_len[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 150 == 149) begin
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        step("rnd_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) pkt_len[i] = 0;
      end
      for (int i = 0; i < 5; i++) begin
        if (pkt_len[i] == 0 && $urandom_range(0, 2) == 0) begin
          pkt_len[i]  = $urandom_range(1, 4);
          pkt_dest[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
        end
        bus.req[i]       = (pkt_len[i] > 0) && ($urandom_range(0, 4) != 0);
        bus.dest[i]      = (pkt_len[i] > 0) ? 3'(pkt_dest[i]) : 3'($urandom_range(0, 7));
        bus.tail[i]      = (pkt_len[i] > 0) ? (pkt_len[i] == 1) : 1'($urandom_range(0, 1));
        bus.out_ready[i] = ($urandom_range(0, 3) != 0);
      end
      step("rnd");
      for (int i = 0; i < 5; i++) begin
        if (m_grant[i]) pkt_len[i]--;
        else if (pkt_len[i] > 0 && pkt_dest[i] > 4) pkt_len[i]--;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
